// File: rtl/simd_seq_pkg.sv
// Shared types and sizes for the SIMD word sequencer.
package simd_seq_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BEATS      = 4;
  localparam int unsigned VEC_W      = WORD_W * BEATS;
  localparam int unsigned BEAT_CNT_W = 2;
  localparam int unsigned ALU_SEL_W  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } seq_state_e;

endpackage

// File: rtl/simd_word_sequencer.sv
// Splits a 128-bit operand pair into 32-bit ALU beats and reassembles the results.
// Optional macro SIMD_SEQ_PERF_CNT_EN adds the ops_done completed-vector counter.
module simd_word_sequencer #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BEATS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W*BEATS-1:0]    in_a,
  input  logic [WORD_W*BEATS-1:0]    in_b,
  input  logic [1:0]                 in_sel,
  output logic [WORD_W-1:0]          alu_a,
  output logic [WORD_W-1:0]          alu_b,
  output logic [1:0]                 alu_sel,
  output logic                       alu_issue,
  input  logic [WORD_W-1:0]          alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W*BEATS-1:0]    out_result
`ifdef SIMD_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]                ops_done
`endif
);

  import simd_seq_pkg::*;

  localparam int unsigned VecW  = WORD_W * BEATS;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  seq_state_e           state_q;
  logic [BeatW-1:0]     beat_q;
  logic [VecW-1:0]      a_q;
  logic [VecW-1:0]      b_q;
  logic [ALU_SEL_W-1:0] sel_q;

  // Sequencer FSM: latch operands, step through beats, hold result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      in_ready   <= 1'b1;
      alu_issue  <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            sel_q      <= in_sel;
            beat_q     <= '0;
            out_result <= '0;
            in_ready   <= 1'b0;
            alu_issue  <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          out_result[beat_q*WORD_W +: WORD_W] <= alu_result;
          if (beat_q == LastBeat) begin
            alu_issue <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Beat slice mux; ALU inputs are forced to zero whenever no beat is issuing.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (alu_issue) begin
      alu_a   = a_q[beat_q*WORD_W +: WORD_W];
      alu_b   = b_q[beat_q*WORD_W +: WORD_W];
      alu_sel = sel_q;
    end
  end

`ifdef SIMD_SEQ_PERF_CNT_EN
  // Completed-vector counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done <= '0;
    end else if (out_valid && out_ready) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_simd_word_sequencer.sv
// Self-checking bench for simd_word_sequencer; bench ALU computes a ^ b.
// Define SIMD_SEQ_PERF_CNT_EN to also exercise the ops_done counter.
module tb_simd_word_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic [1:0]   in_sel;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [1:0]   alu_sel;
  logic         alu_issue;
  logic [31:0]  alu_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_result;
`ifdef SIMD_SEQ_PERF_CNT_EN
  logic [15:0]  ops_done;
`endif

  int n_cmp;
  int n_err;

  simd_word_sequencer #(
    .WORD_W(32),
    .BEATS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_issue (alu_issue),
    .alu_result(alu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result)
`ifdef SIMD_SEQ_PERF_CNT_EN
    ,
    .ops_done  (ops_done)
`endif
  );

  // Bench ALU: lane-wise XOR is just a full-word XOR.
  assign alu_result = alu_a ^ alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 128'h0 || alu_issue !== 1'b0
        || alu_a !== 32'h0 || alu_b !== 32'h0 || alu_sel !== 2'b00) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_result=%h alu_issue=%b alu_a=%h alu_b=%h sel=%b, required 1 0 0 0 0 0 0",
               in_ready, out_valid, out_result, alu_issue, alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_single_op();
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp;
    logic [1:0]   s;
    for (int v = 0; v < 7; v++) begin
      if (v == 0) begin
        a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        b = {16{8'h0F}};
        s = 2'b10;
      end else begin
        a = rand128();
        b = rand128();
        s = 2'($urandom_range(0, 3));
      end
      exp = a ^ b;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_sel = s; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        // Scramble inputs after accept; the sequencer must use its latched copy.
        in_valid = 1'b0; in_a = rand128(); in_b = rand128(); in_sel = ~s;
        n_cmp++;
        if (alu_issue !== 1'b1 || in_ready !== 1'b0 || alu_a !== a[k*32 +: 32]
            || alu_b !== b[k*32 +: 32] || alu_sel !== s) begin
          n_err++;
          $display("FAIL single_beat v%0d k%0d: issue=%b ready=%b a=%h b=%h sel=%b, required 1 0 %h %h %b",
                   v, k, alu_issue, in_ready, alu_a, alu_b, alu_sel, a[k*32 +: 32], b[k*32 +: 32], s);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== exp || alu_issue !== 1'b0) begin
        n_err++;
        $display("FAIL single_result v%0d: valid=%b issue=%b result=%h, required 1 0 %h",
                 v, out_valid, alu_issue, out_result, exp);
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 32'h0 || out_result !== exp) begin
        n_err++;
        $display("FAIL single_release v%0d: valid=%b ready=%b alu_a=%h result=%h, required 0 1 0 %h",
                 v, out_valid, in_ready, alu_a, out_result, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp;
    bit           bad;
    a = rand128();
    b = rand128();
    exp = a ^ b;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sel = 2'b10; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      // A pulse of out_ready while issuing must not consume anything.
      out_ready = (k == 1);
    end
    out_ready = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = rand128(); in_b = rand128();
      if (out_valid !== 1'b1 || out_result !== exp || in_ready !== 1'b0 || alu_issue !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL backpressure_hold c%0d: valid=%b ready=%b issue=%b result=%h, required 1 0 0 %h",
                 c, out_valid, in_ready, alu_issue, out_result, exp);
      end
    end
    n_cmp++;
    if (bad) n_err++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] va[3];
    logic [127:0] vb[3];
    logic [127:0] exp_q[$];
    int           presented;
    int           results;
    int           beats_seen;
    int           vi;
    int           bi;
    int           last_res;
    bit           bad;
    for (int i = 0; i < 3; i++) begin
      va[i] = rand128();
      vb[i] = rand128();
    end
    presented = 0; results = 0; beats_seen = 0; bad = 1'b0; last_res = -100;
    out_ready = 1'b1;
    in_sel = 2'b10;
    for (int c = 0; c < 60 && results < 3; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && (alu_issue !== 1'b0 || out_valid !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL b2b_overlap c%0d: ready=%b issue=%b valid=%b", c, in_ready, alu_issue, out_valid);
      end
      if (alu_issue === 1'b1) begin
        vi = beats_seen / 4;
        bi = beats_seen % 4;
        if (vi > 2 || alu_a !== va[vi][bi*32 +: 32] || alu_b !== vb[vi][bi*32 +: 32]) begin
          bad = 1'b1;
          $display("FAIL b2b_beat c%0d: alu_a=%h alu_b=%h at vector %0d beat %0d", c, alu_a, alu_b, vi, bi);
        end
        beats_seen++;
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0 || out_result !== exp_q[0] || c - last_res < 5) begin
          bad = 1'b1;
          $display("FAIL b2b_result c%0d: result=%h, required %h (gap %0d)",
                   c, out_result, (exp_q.size() != 0) ? exp_q[0] : 128'h0, c - last_res);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        last_res = c;
        results++;
        if (results == 3) in_valid = 1'b0;
      end
      if (in_ready === 1'b1) begin
        if (presented < 3) begin
          in_valid = 1'b1; in_a = va[presented]; in_b = vb[presented];
          exp_q.push_back(va[presented] ^ vb[presented]);
          presented++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad || results != 3 || beats_seen != 12) begin
      n_err++;
      $display("FAIL b2b_summary: results=%0d beats=%0d, required 3 12", results, beats_seen);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_issue !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: ready=%b valid=%b issue=%b, required 1 0 0", in_ready, out_valid, alu_issue);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] a;
    bit           seen;
    a = rand128();
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = rand128(); out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    n_cmp++;
    if (alu_issue !== 1'b1 || alu_a !== a[64 +: 32]) begin
      n_err++;
      $display("FAIL reset_mid_beat2: issue=%b alu_a=%h, required 1 %h", alu_issue, alu_a, a[64 +: 32]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || alu_issue !== 1'b0 || out_valid !== 1'b0 || out_result !== 128'h0
        || alu_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_idle: ready=%b issue=%b valid=%b result=%h alu_a=%h, required 1 0 0 0 0",
               in_ready, alu_issue, out_valid, out_result, alu_a);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || alu_issue !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_mid_abort: aborted vector produced activity, required none");
    end
  endtask

`ifdef SIMD_SEQ_PERF_CNT_EN
  task automatic test_perf_cnt();
    n_cmp++;
    if (ops_done !== 16'd0) begin
      n_err++;
      $display("FAIL perf_cnt_reset: ops_done=%0d, required 0", ops_done);
    end
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = rand128(); in_b = rand128();
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
    end
    n_cmp++;
    if (ops_done !== 16'd3) begin
      n_err++;
      $display("FAIL perf_cnt_count: ops_done=%0d, required 3", ops_done);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sel = 2'b00;
    out_ready = 1'b0;
    test_reset();
    test_single_op();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef SIMD_SEQ_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
